// File: rtl/tlb_ptw_pkg.sv
// Shared constants for the Sv32 page-table walker: widths, PTE bit positions
// and walker state encodings.
package tlb_ptw_pkg;

  localparam int unsigned VPN_W_DEF = 20;
  localparam int unsigned PPN_W_DEF = 22;
  localparam int unsigned PA_W_DEF  = 34;
  localparam int unsigned PTE_W_DEF = 32;
  localparam int unsigned IDX_W     = 10;

  localparam int unsigned PTE_BIT_V  = 0;
  localparam int unsigned PTE_BIT_R  = 1;
  localparam int unsigned PTE_BIT_W  = 2;
  localparam int unsigned PTE_BIT_X  = 3;
  localparam int unsigned PTE_BIT_U  = 4;
  localparam int unsigned PTE_BIT_G  = 5;
  localparam int unsigned PTE_BIT_A  = 6;
  localparam int unsigned PTE_BIT_D  = 7;
  localparam int unsigned PTE_PPN_LO = 10;
  localparam int unsigned PTE_PPN_HI = 31;

  typedef enum logic [2:0] {
    PTW_IDLE     = 3'd0,
    PTW_MEM_REQ  = 3'd1,
    PTW_MEM_WAIT = 3'd2,
    PTW_CHECK    = 3'd3,
    PTW_RESPOND  = 3'd4
  } ptw_state_e;

endpackage

// File: rtl/tlb_pte_check.sv
// Combinational Sv32 PTE decode: classifies a PTE at a given level as leaf,
// fault or pointer, and expands superpage PPNs with the low VPN index.
module tlb_pte_check
  import tlb_ptw_pkg::*;
(
  input  logic [PTE_W_DEF-1:0] pte,
  input  logic                 level,
  input  logic [IDX_W-1:0]     vpn_lo,
  output logic                 leaf,
  output logic                 fault,
  output logic [PPN_W_DEF-1:0] ppn
);

  logic unused_rsw;

  always_comb begin
    leaf       = 1'b0;
    fault      = 1'b0;
    ppn        = '0;
    unused_rsw = ^pte[PTE_PPN_LO-1 -: 2];
    if (!pte[PTE_BIT_V] || (pte[PTE_BIT_W] && !pte[PTE_BIT_R])) begin
      fault = 1'b1;
    end else if (pte[PTE_BIT_R] || pte[PTE_BIT_X]) begin
      // a level-1 leaf must be 4 MiB aligned
      if (level && (pte[PTE_PPN_LO +: IDX_W] != '0)) begin
        fault = 1'b1;
      end else begin
        leaf = 1'b1;
        ppn  = level ? {pte[PTE_PPN_HI -: (PPN_W_DEF - IDX_W)], vpn_lo}
                     : pte[PTE_PPN_HI:PTE_PPN_LO];
      end
    end else if (!level) begin
      fault = 1'b1;
    end
  end

endmodule

// File: rtl/tlb_ptw.sv
// Two-level Sv32 page-table walker: one walk at a time, single-outstanding
// PTE reads, registered response to the TLB controller.
module tlb_ptw
  import tlb_ptw_pkg::*;
#(
  parameter int unsigned VPN_W = VPN_W_DEF,
  parameter int unsigned PPN_W = PPN_W_DEF,
  parameter int unsigned PA_W  = PA_W_DEF,
  parameter int unsigned PTE_W = PTE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PPN_W-1:0] satp_ppn_i,
  input  logic             ptw_req_valid_i,
  output logic             ptw_req_ready_o,
  input  logic [VPN_W-1:0] ptw_req_vpn_i,
  output logic             ptw_resp_valid_o,
  input  logic             ptw_resp_ready_i,
  output logic [PPN_W-1:0] ptw_resp_ppn_o,
  output logic [7:0]       ptw_resp_flags_o,
  output logic             ptw_resp_super_o,
  output logic             ptw_resp_fault_o,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [PA_W-1:0]  mem_req_addr_o,
  input  logic             mem_resp_valid_i,
  output logic             mem_resp_ready_o,
  input  logic [PTE_W-1:0] mem_resp_data_i
);

  ptw_state_e       state_q, state_d;
  logic             level_q;
  logic [VPN_W-1:0] vpn_q;
  logic [PPN_W-1:0] table_ppn_q;
  logic [PTE_W-1:0] pte_q;
  logic [PPN_W-1:0] resp_ppn_q;
  logic [7:0]       resp_flags_q;
  logic             resp_super_q;
  logic             resp_fault_q;
  logic [IDX_W-1:0] idx;
  logic             chk_leaf;
  logic             chk_fault;
  logic [PPN_W-1:0] chk_ppn;

  tlb_pte_check u_pte_check (
    .pte    (pte_q),
    .level  (level_q),
    .vpn_lo (vpn_q[IDX_W-1:0]),
    .leaf   (chk_leaf),
    .fault  (chk_fault),
    .ppn    (chk_ppn)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= PTW_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = PTW_IDLE;
    case (state_q)
      PTW_IDLE:     state_d = ptw_req_valid_i ? PTW_MEM_REQ : PTW_IDLE;
      PTW_MEM_REQ:  state_d = mem_req_ready_i ? PTW_MEM_WAIT : PTW_MEM_REQ;
      PTW_MEM_WAIT: state_d = mem_resp_valid_i ? PTW_CHECK : PTW_MEM_WAIT;
      PTW_CHECK:    state_d = (chk_fault || chk_leaf) ? PTW_RESPOND : PTW_MEM_REQ;
      PTW_RESPOND:  state_d = ptw_resp_ready_i ? PTW_IDLE : PTW_RESPOND;
      default:      state_d = PTW_IDLE;
    endcase
  end

  always_comb begin
    ptw_req_ready_o  = (state_q == PTW_IDLE);
    mem_req_valid_o  = (state_q == PTW_MEM_REQ);
    mem_resp_ready_o = (state_q == PTW_MEM_WAIT);
    ptw_resp_valid_o = (state_q == PTW_RESPOND);
    ptw_resp_ppn_o   = resp_ppn_q;
    ptw_resp_flags_o = resp_flags_q;
    ptw_resp_super_o = resp_super_q;
    ptw_resp_fault_o = resp_fault_q;
  end

  // Address is a pure function of walk registers, so it stays put while stalled.
  always_comb begin
    idx            = level_q ? vpn_q[VPN_W-1 -: IDX_W] : vpn_q[IDX_W-1:0];
    mem_req_addr_o = {table_ppn_q, idx, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      level_q      <= 1'b0;
      vpn_q        <= '0;
      table_ppn_q  <= '0;
      pte_q        <= '0;
      resp_ppn_q   <= '0;
      resp_flags_q <= '0;
      resp_super_q <= 1'b0;
      resp_fault_q <= 1'b0;
    end else begin
      case (state_q)
        PTW_IDLE: begin
          if (ptw_req_valid_i) begin
            vpn_q       <= ptw_req_vpn_i;
            table_ppn_q <= satp_ppn_i;
            level_q     <= 1'b1;
          end
        end
        PTW_MEM_WAIT: begin
          if (mem_resp_valid_i) pte_q <= mem_resp_data_i;
        end
        PTW_CHECK: begin
          if (chk_fault) begin
            resp_ppn_q   <= '0;
            resp_flags_q <= '0;
            resp_super_q <= 1'b0;
            resp_fault_q <= 1'b1;
          end else if (chk_leaf) begin
            resp_ppn_q   <= chk_ppn;
            resp_flags_q <= pte_q[7:0];
            resp_super_q <= level_q;
            resp_fault_q <= 1'b0;
          end else begin
            table_ppn_q <= pte_q[PTE_PPN_HI:PTE_PPN_LO];
            level_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_ptw.sv
// Self-checking bench for tlb_ptw: directed walks, back-pressure, mid-walk
// reset and randomized walks against an arithmetic Sv32 translation model.
module tb_tlb_ptw;

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] satp_ppn_i;
  logic        ptw_req_valid_i;
  logic        ptw_req_ready_o;
  logic [19:0] ptw_req_vpn_i;
  logic        ptw_resp_valid_o;
  logic        ptw_resp_ready_i;
  logic [21:0] ptw_resp_ppn_o;
  logic [7:0]  ptw_resp_flags_o;
  logic        ptw_resp_super_o;
  logic        ptw_resp_fault_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [33:0] mem_req_addr_o;
  logic        mem_resp_valid_i;
  logic        mem_resp_ready_o;
  logic [31:0] mem_resp_data_i;

  logic [31:0] c_pte;
  logic        c_level;
  logic [9:0]  c_vpn_lo;
  logic        c_leaf;
  logic        c_fault;
  logic [21:0] c_ppn;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tlb_ptw dut (
    .clk              (clk),
    .rst              (rst),
    .satp_ppn_i       (satp_ppn_i),
    .ptw_req_valid_i  (ptw_req_valid_i),
    .ptw_req_ready_o  (ptw_req_ready_o),
    .ptw_req_vpn_i    (ptw_req_vpn_i),
    .ptw_resp_valid_o (ptw_resp_valid_o),
    .ptw_resp_ready_i (ptw_resp_ready_i),
    .ptw_resp_ppn_o   (ptw_resp_ppn_o),
    .ptw_resp_flags_o (ptw_resp_flags_o),
    .ptw_resp_super_o (ptw_resp_super_o),
    .ptw_resp_fault_o (ptw_resp_fault_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .mem_resp_data_i  (mem_resp_data_i)
  );

  tlb_pte_check u_chk (
    .pte    (c_pte),
    .level  (c_level),
    .vpn_lo (c_vpn_lo),
    .leaf   (c_leaf),
    .fault  (c_fault),
    .ppn    (c_ppn)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-level PTE meaning, straight from the Sv32 rules.
  function automatic void ref_decode(input logic [31:0] pte, input bit lvl1, input logic [9:0] vlo,
                                     output bit leaf, output bit flt, output logic [21:0] ppn);
    int unsigned p;
    bit v, r, w, x;
    p = pte;
    v = p[0]; r = p[1]; w = p[2]; x = p[3];
    leaf = 1'b0; flt = 1'b0; ppn = '0;
    if (!v || (w && !r)) flt = 1'b1;
    else if (r || x) begin
      if (lvl1 && ((p >> 10) % 1024) != 0) flt = 1'b1;
      else begin
        leaf = 1'b1;
        ppn  = lvl1 ? 22'((p >> 20) * 1024 + int'(vlo)) : 22'(p >> 10);
      end
    end else if (!lvl1) flt = 1'b1;
  endfunction

  function automatic void ref_walk(input logic [21:0] satp, input logic [19:0] vpn,
                                   input logic [31:0] pte1, input logic [31:0] pte0,
                                   output logic [33:0] a1, output logic [33:0] a0, output int nreq,
                                   output logic [21:0] ppn, output logic [7:0] flags,
                                   output bit sup, output bit flt);
    bit leaf;
    logic [21:0] lp;
    a1 = 34'(satp) * 4096 + 34'(vpn / 1024) * 4;
    a0 = '0; nreq = 1; ppn = '0; flags = '0; sup = 1'b0;
    ref_decode(pte1, 1'b1, 10'(vpn % 1024), leaf, flt, lp);
    if (!flt && leaf) begin
      ppn = lp; flags = pte1[7:0]; sup = 1'b1;
    end else if (!flt) begin
      nreq = 2;
      a0 = 34'(pte1 >> 10) * 4096 + 34'(vpn % 1024) * 4;
      ref_decode(pte0, 1'b0, 10'(vpn % 1024), leaf, flt, lp);
      if (!flt) begin ppn = lp; flags = pte0[7:0]; end
    end
  endfunction

  // kind: 0 invalid, 1 W-without-R, 2 leaf, 3 misaligned leaf, 4 pointer
  function automatic logic [31:0] gen_pte(input int unsigned kind, input bit lvl1);
    logic [31:0] p;
    p = $urandom;
    case (kind)
      0: p[0] = 1'b0;
      1: begin p[0] = 1'b1; p[1] = 1'b0; p[2] = 1'b1; end
      2, 3: begin
        p[0] = 1'b1; p[1] = 1'b1;
        if (p[4]) begin p[1] = 1'b0; p[2] = 1'b0; p[3] = 1'b1; end
        if (kind == 2 && lvl1) p[19:10] = '0;
        if (kind == 3) p[10] = 1'b1;
      end
      default: begin p[0] = 1'b1; p[3:1] = 3'b000; end
    endcase
    return p;
  endfunction

  task automatic run_walk(input logic [21:0] satp, input logic [19:0] vpn,
                          input logic [31:0] pte1, input logic [31:0] pte0,
                          input int req_stall, input int data_delay, input int resp_stall,
                          input bit zero_wait);
    logic [33:0] a1, a0;
    int nreq_exp;
    logic [21:0] eppn;
    logic [7:0] efl;
    bit esup, eflt;
    int nreq = 0, stall = 0, wait_cnt = 0, cyc = 0, hold = 0;
    bit pend = 1'b0, done = 1'b0;
    ref_walk(satp, vpn, pte1, pte0, a1, a0, nreq_exp, eppn, efl, esup, eflt);
    chk("idle_req_ready", ptw_req_ready_o, 1);
    ptw_req_valid_i = 1'b1;
    ptw_req_vpn_i   = vpn;
    satp_ppn_i      = satp;
    @(posedge clk); #1;
    // keep a junk request pending while busy: it must be neither accepted nor latched
    ptw_req_vpn_i = 20'($urandom);
    satp_ppn_i    = 22'($urandom);
    while (!done && cyc < 300) begin
      cyc++;
      chk("busy_req_ready", ptw_req_ready_o, 0);
      if (cyc == 1) chk("accept_mem_valid", mem_req_valid_o, 1);
      if (pend) chk("no_req_while_wait", mem_req_valid_o, 0);
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = 1'b0;
      mem_resp_data_i  = $urandom;
      if (mem_req_valid_o) begin
        chk("mem_addr", mem_req_addr_o, (nreq == 0) ? a1 : a0);
        if (stall >= req_stall) begin
          mem_req_ready_i = 1'b1; stall = 0; nreq++; pend = 1'b1; wait_cnt = 0;
        end else begin
          stall++;
          mem_resp_valid_i = 1'b1;
        end
      end else if (pend) begin
        if (wait_cnt >= data_delay) begin
          mem_resp_valid_i = 1'b1;
          mem_resp_data_i  = (nreq == 1) ? pte1 : pte0;
          if (mem_resp_ready_o) pend = 1'b0;
        end else wait_cnt++;
      end
      if (ptw_resp_valid_o) begin
        if (hold == 0) begin
          if (zero_wait) chk("latency", cyc, (nreq_exp == 2) ? 9 : 5);
          chk("mem_req_count", nreq, nreq_exp);
        end
        chk("resp_ppn", ptw_resp_ppn_o, eppn);
        chk("resp_flags", ptw_resp_flags_o, efl);
        chk("resp_super", ptw_resp_super_o, esup);
        chk("resp_fault", ptw_resp_fault_o, eflt);
        if (hold >= resp_stall) begin
          ptw_resp_ready_i = 1'b1; ptw_req_valid_i = 1'b0; done = 1'b1;
        end else begin
          hold++; ptw_resp_ready_i = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    chk("walk_done", done, 1);
    ptw_req_valid_i  = 1'b0;
    ptw_resp_ready_i = 1'b0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    chk("resp_valid_drop", ptw_resp_valid_o, 0);
    chk("req_ready_rise", ptw_req_ready_o, 1);
  endtask

  initial begin
    bit r_leaf, r_flt;
    logic [21:0] r_ppn;
    int k;
    int cnt;
    logic [21:0] rs;
    logic [19:0] rv;
    rst = 1'b0;
    satp_ppn_i = '0; ptw_req_valid_i = 1'b0; ptw_req_vpn_i = '0; ptw_resp_ready_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
    c_pte = '0; c_level = 1'b0; c_vpn_lo = '0;

    for (int i = 0; i < 40; i++) begin
      c_level  = 1'($urandom);
      c_pte    = gen_pte($urandom_range(0, 4), c_level);
      c_vpn_lo = 10'($urandom);
      #1;
      ref_decode(c_pte, c_level, c_vpn_lo, r_leaf, r_flt, r_ppn);
      chk("pte_check_leaf", c_leaf, r_leaf);
      chk("pte_check_fault", c_fault, r_flt);
      chk("pte_check_ppn", c_ppn, r_ppn);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", ptw_req_ready_o, 1);
    chk("rst_resp_valid", ptw_resp_valid_o, 0);
    chk("rst_mem_req_valid", mem_req_valid_o, 0);
    chk("rst_mem_resp_ready", mem_resp_ready_o, 0);
    chk("rst_resp_ppn", ptw_resp_ppn_o, 0);
    chk("rst_resp_flags", ptw_resp_flags_o, 0);
    chk("rst_resp_super", ptw_resp_super_o, 0);
    chk("rst_resp_fault", ptw_resp_fault_o, 0);
    chk("rst_mem_addr", mem_req_addr_o, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_walk(22'h00100, 20'h12345, 32'h00400001, 32'h00ABC0CF, 0, 1, 0, 1'b1);
    run_walk(22'h00100, 20'h12345, 32'h2000000F, 32'h0, 0, 1, 0, 1'b1);
    run_walk(22'h00100, 20'h12345, 32'h00000000, 32'h0, 0, 1, 0, 1'b1);
    run_walk(22'h00100, 20'h12345, 32'h0000040B, 32'h0, 0, 1, 0, 1'b1);
    run_walk(22'h00100, 20'h12345, 32'h00400001, 32'h00000001, 0, 1, 0, 1'b1);
    run_walk(22'h00100, 20'h12345, 32'h00400001, 32'h00ABC0CF, 3, 4, 5, 1'b0);

    // reset while waiting for PTE data, then a stale response arrives
    ptw_req_valid_i = 1'b1; ptw_req_vpn_i = 20'h0ABCD; satp_ppn_i = 22'h00321;
    @(posedge clk); #1;
    ptw_req_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    cnt = 0;
    while (!mem_resp_ready_o && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    mem_req_ready_i = 1'b0;
    chk("reach_mem_wait", mem_resp_ready_o, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst_req_ready", ptw_req_ready_o, 1);
    chk("midrst_resp_valid", ptw_resp_valid_o, 0);
    chk("midrst_mem_req_valid", mem_req_valid_o, 0);
    chk("midrst_mem_resp_ready", mem_resp_ready_o, 0);
    for (int i = 0; i < 3; i++) begin
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = 32'h2000000F;
      @(posedge clk); #1;
      chk("stale_mem_resp_ready", mem_resp_ready_o, 0);
      chk("stale_req_ready", ptw_req_ready_o, 1);
      chk("stale_mem_req_valid", mem_req_valid_o, 0);
      chk("stale_resp_valid", ptw_resp_valid_o, 0);
    end
    mem_resp_valid_i = 1'b0;
    run_walk(22'h00100, 20'h12345, 32'h00400001, 32'h00ABC0CF, 0, 1, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      int rq, rd, rr;
      logic [31:0] p1, p0;
      rs = 22'($urandom);
      rv = 20'($urandom);
      k  = $urandom_range(0, 4);
      p1 = gen_pte(k, 1'b1);
      p0 = gen_pte($urandom_range(0, 4), 1'b0);
      rq = $urandom_range(0, 2);
      rd = $urandom_range(0, 3);
      rr = $urandom_range(0, 2);
      run_walk(rs, rv, p1, p0, rq, rd, rr, (rq == 0) && (rd == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
